inference_sequencer: RTL and testbench
======================================

Name: inference_sequencer

Overview:
- Sequences a single shared MAC engine across the three fully-connected layers of the digit-recognition network, one output neuron at a time.
- Writes ReLU'd hidden activations back to the activation buffer.
- Tracks the running argmax of the final layer and reports the winning digit with sticky overflow and done flags.
- Sits between the top-level control FSM (start/done) and the MAC/activation-buffer datapath inside the TPU.

Parameters:
- OUT0, 64, neuron count of layer 0; input length fixed at 1024 (32x32 image)
- OUT1, 32, neuron count of layer 1; input length OUT0
- OUT2, 10, neuron count of layer 2 (digits); input length OUT1
- ACC_W, 32, MAC accumulator width, signed two's complement
- TIMEOUT, 4096, maximum sysClk cycles to wait for mac_done before abort

Ports:
- sysClk  in  1  clock
- iRst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins inference
- busy  out  1  high from the cycle after an accepted start until DONE is entered
- mac_start  out  1  one-cycle pulse requesting one neuron dot-product
- mac_layer  out  2  layer index 0..2, held stable from mac_start until mac_done
- mac_neuron  out  10  neuron index within the layer, held stable likewise
- mac_in_len  out  11  dot-product length for the current layer (1024/OUT0/OUT1)
- mac_done  in  1  one-cycle pulse; mac_result and mac_ovf are valid in this cycle
- mac_result  in  ACC_W  signed accumulator result
- mac_ovf  in  1  accumulator saturated during this dot-product
- wr_en  out  1  activation-buffer write strobe
- wr_layer  out  2  destination layer of the write (0 or 1)
- wr_addr  out  10  neuron index of the write
- wr_data  out  ACC_W  ReLU(mac_result)
- num_out  out  4  recognised digit 0..9; 4'hF on abort
- overflow  out  1  sticky OR of mac_ovf plus timeout; cleared by start
- done  out  1  high in DONE; cleared by start

Behaviour:
- Reset (iRst_n=0 at a sysClk edge): state=IDLE; all outputs 0 except num_out=0; internal counters 0. Reset mid-operation aborts immediately; late mac_done pulses are ignored because the state is IDLE.
- States: IDLE, ISSUE, WAIT, WRITE, NEXT, DONE.
- IDLE / DONE, on start:
  - layer=0, neuron=0, overflow=0, done=0
  - best_val=most negative ACC_W value, best_idx=0
  - next state ISSUE
- start is ignored in ISSUE/WAIT/WRITE/NEXT.
- ISSUE: mac_start=1 for exactly one cycle; wait counter cleared; next state WAIT.
- WAIT:
  - On mac_done: latch mac_result; overflow |= mac_ovf; next state WRITE.
  - Otherwise increment wait counter. When it reaches TIMEOUT-1 with no mac_done: overflow=1, num_out=4'hF, next state DONE.
  - mac_done in any other state is ignored.
- WRITE:
  - Layers 0/1: wr_en=1 for one cycle with wr_layer=layer, wr_addr=neuron, wr_data = latched result if >=0, else 0.
  - Layer 2: no write. If result > best_val (signed, strict), update best_val and best_idx=neuron. Ties keep the lower index.
  - Next state NEXT.
- NEXT:
  - If neuron == OUTn-1 of the current layer:
    - layer 2: num_out=best_idx, next state DONE
    - else: layer+1, neuron=0, next state ISSUE
  - Else neuron+1, next state ISSUE.
- DONE: done=1 and held; num_out and overflow held until the next start.
- mac_in_len is combinational from layer: 0→1024, 1→OUT0, 2→OUT1.
- Latency: 4 sequencer cycles per neuron plus MAC latency.
  - Total = 4*(OUT0+OUT1+OUT2) + sum of MAC latencies + 1 (DONE entry) cycles from the start edge.
- busy=0 and done=1 are asserted in the same cycle.
- Neuron counter wrap: never exceeds OUTn-1; the layer counter never exceeds 2.

Test Plan:
- Reset mid-WAIT (layer 1, neuron 5), then a late mac_done → all outputs 0, state IDLE, no wr_en, no mac_start.
- Model MAC with 3-cycle latency, results = neuron index for layers 0/1; layer 2 results all -5 except neuron 7 = +100 → 64+32 writes with correct addresses, num_out=7, done=1, overflow=0, completion in 4*106+3*106+1 = 743 cycles.
- Negative hidden results (-20) → wr_data=0.
- Layer 2 results all equal (0) → num_out=0.
- Layer 2 neuron 9 = 0x7FFFFFFF, others 0x80000000 → num_out=9.
- mac_ovf pulsed once on layer 0 neuron 3 → overflow=1 at done, num_out still valid.
- A second start after done → overflow and done cleared.
- MAC never responds on layer 1 neuron 0 → after TIMEOUT cycles: overflow=1, num_out=4'hF, done=1.
- start pulses during busy → ignored, sequence unchanged.

Source files
------------

// File: rtl/inference_sequencer_if.sv
// -----------------------------------------------------------------------------
// inference_sequencer_if
// Bus between the inference sequencer and the MAC / activation-buffer datapath.
//   MAC request : mac_start, mac_layer, mac_neuron, mac_in_len (sequencer -> MAC)
//   MAC response: mac_done, mac_result, mac_ovf                (MAC -> sequencer)
//   Buffer write: wr_en, wr_layer, wr_addr, wr_data            (sequencer -> buffer)
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface inference_sequencer_if #(
  parameter int ACC_W = 32
);
  logic                    mac_start;
  logic [1:0]              mac_layer;
  logic [9:0]              mac_neuron;
  logic [10:0]             mac_in_len;
  logic                    mac_done;
  logic signed [ACC_W-1:0] mac_result;
  logic                    mac_ovf;
  logic                    wr_en;
  logic [1:0]              wr_layer;
  logic [9:0]              wr_addr;
  logic signed [ACC_W-1:0] wr_data;

  modport master (
    output mac_start, mac_layer, mac_neuron, mac_in_len,
    output wr_en, wr_layer, wr_addr, wr_data,
    input  mac_done, mac_result, mac_ovf
  );

  modport slave (
    input  mac_start, mac_layer, mac_neuron, mac_in_len,
    input  wr_en, wr_layer, wr_addr, wr_data,
    output mac_done, mac_result, mac_ovf
  );
endinterface

// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
// Walks one shared MAC engine across the three fully-connected layers of the
// digit-recognition network, one output neuron at a time. Hidden-layer results
// are ReLU'd and written back to the activation buffer; the final layer is
// reduced to a running argmax that becomes the recognised digit.
//
// Ports:
//   sysClk      in   clock
//   iRst_n      in   synchronous active-low reset
//   start_i     in   one-cycle pulse, begins an inference (IDLE/DONE only)
//   bus         master modport of inference_sequencer_if (MAC + buffer write)
//   busy_o      out  inference in progress
//   num_out_o   out  recognised digit 0..9, 4'hF after a MAC timeout
//   overflow_o  out  sticky MAC saturation / timeout flag, cleared by start
//   done_o      out  high while in DONE, cleared by start
// -----------------------------------------------------------------------------
module inference_sequencer #(
  parameter int OUT0    = 64,
  parameter int OUT1    = 32,
  parameter int OUT2    = 10,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                 sysClk,
  input  logic                 iRst_n,
  input  logic                 start_i,
  inference_sequencer_if.master bus,
  output logic                 busy_o,
  output logic [3:0]           num_out_o,
  output logic                 overflow_o,
  output logic                 done_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT, DONE} state_t;

  state_t                  state_q,    state_d;
  logic [1:0]              layer_q,    layer_d;
  logic [9:0]              neuron_q,   neuron_d;
  logic [WCNT_W-1:0]       wcnt_q,     wcnt_d;
  logic                    ovf_q,      ovf_d;
  logic [3:0]              num_q,      num_d;
  logic [3:0]              best_idx_q, best_idx_d;
  logic signed [ACC_W-1:0] best_val_q, best_val_d;
  logic signed [ACC_W-1:0] result_q,   result_d;

  function automatic logic [9:0] last_neuron(input logic [1:0] l);
    case (l)
      2'd0:    return 10'(OUT0 - 1);
      2'd1:    return 10'(OUT1 - 1);
      default: return 10'(OUT2 - 1);
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
    return x[ACC_W-1] ? '0 : x;
  endfunction

  // State register: control state is reset, datapath values are not
  always_ff @(posedge sysClk) begin
    if (!iRst_n) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      neuron_q   <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      num_q      <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      neuron_q   <= neuron_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      num_q      <= num_d;
      best_idx_q <= best_idx_d;
    end
  end

  always_ff @(posedge sysClk) begin
    best_val_q <= best_val_d;
    result_q   <= result_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    neuron_d   = neuron_q;
    wcnt_d     = wcnt_q;
    ovf_d      = ovf_q;
    num_d      = num_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    result_d   = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          layer_d    = '0;
          neuron_d   = '0;
          ovf_d      = 1'b0;
          num_d      = '0;
          best_val_d = ACC_MIN;
          best_idx_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mac_done) begin
          result_d = bus.mac_result;
          ovf_d    = ovf_q | bus.mac_ovf;
          state_d  = WRITE;
        end else if (wcnt_q == WCNT_LAST) begin
          // MAC never answered: abort the whole inference
          ovf_d   = 1'b1;
          num_d   = 4'hF;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      WRITE: begin
        // Strict compare so ties keep the lower neuron index
        if (layer_q == 2'd2 && result_q > best_val_q) begin
          best_val_d = result_q;
          best_idx_d = neuron_q[3:0];
        end
        state_d = NEXT;
      end
      NEXT: begin
        if (neuron_q == last_neuron(layer_q)) begin
          if (layer_q == 2'd2) begin
            num_d   = best_idx_q;
            state_d = DONE;
          end else begin
            layer_d  = layer_q + 2'd1;
            neuron_d = '0;
            state_d  = ISSUE;
          end
        end else begin
          neuron_d = neuron_q + 10'd1;
          state_d  = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.mac_start  = (state_q == ISSUE);
    bus.mac_layer  = layer_q;
    bus.mac_neuron = neuron_q;
    case (layer_q)
      2'd0:    bus.mac_in_len = 11'd1024;
      2'd1:    bus.mac_in_len = 11'(OUT0);
      default: bus.mac_in_len = 11'(OUT1);
    endcase
    bus.wr_en    = (state_q == WRITE) && (layer_q != 2'd2);
    bus.wr_layer = layer_q;
    bus.wr_addr  = neuron_q;
    bus.wr_data  = bus.wr_en ? relu(result_q) : '0;
    busy_o       = (state_q != IDLE) && (state_q != DONE);
    done_o       = (state_q == DONE);
    num_out_o    = num_q;
    overflow_o   = ovf_q;
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inference_sequencer
// Scoreboard bench: each run pushes its expected buffer writes and its expected
// final result into queues before start; a monitor pops and compares whenever
// the DUT strobes wr_en or raises done. A behavioural MAC with 3-cycle latency
// answers each mac_start with directed per-neuron values.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

  logic       sysClk;
  logic       iRst_n;
  logic       start;
  logic       busy;
  logic [3:0] num_out;
  logic       overflow;
  logic       done;

  inference_sequencer_if #(.ACC_W(32)) bus ();

  inference_sequencer #(
    .OUT0(64), .OUT1(32), .OUT2(10), .ACC_W(32), .TIMEOUT(4096)
  ) dut (
    .sysClk    (sysClk),
    .iRst_n    (iRst_n),
    .start_i   (start),
    .bus       (bus),
    .busy_o    (busy),
    .num_out_o (num_out),
    .overflow_o(overflow),
    .done_o    (done)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  int cyc = 0;
  always @(posedge sysClk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int start_cyc = 0;

  // MAC behaviour knobs
  int hid_neg = 0;   // 1: hidden layers return -20
  int l2_mode = 0;   // 0: 7 wins (+100, rest -5); 1: all 0; 2: 9=max, rest=min
  int ovf_l = -1, ovf_n = -1;
  int hang_l = -1, hang_n = -1;

  typedef struct { int l; int a; int d; } wr_t;
  typedef struct { int num; int ovf; int cycles; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mac_val(input int l, input int n);
    if (l < 2) return hid_neg ? -20 : n;
    case (l2_mode)
      0:       return (n == 7) ? 100 : -5;
      1:       return 0;
      default: return (n == 9) ? 32'sh7FFFFFFF : 32'sh80000000;
    endcase
  endfunction

  // Behavioural MAC: answers 4 negedges after seeing mac_start
  initial begin
    int mcnt, ml, mn, exp_len;
    mcnt = 0; ml = 0; mn = 0;
    bus.mac_done = 1'b0; bus.mac_result = '0; bus.mac_ovf = 1'b0;
    forever begin
      @(negedge sysClk);
      bus.mac_done = 1'b0;
      bus.mac_ovf  = 1'b0;
      if (bus.mac_start) begin
        ml = int'(bus.mac_layer);
        mn = int'(bus.mac_neuron);
        exp_len = (ml == 0) ? 1024 : (ml == 1) ? 64 : 32;
        check("mac_in_len", int'(bus.mac_in_len), exp_len);
        mcnt = (ml == hang_l && mn == hang_n) ? 0 : 4;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.mac_done   = 1'b1;
          bus.mac_result = mac_val(ml, mn);
          bus.mac_ovf    = (ml == ovf_l && mn == ovf_n);
        end
      end
    end
  end

  // Monitor
  initial begin
    logic done_prev;
    wr_t  w;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge sysClk);
      if (bus.wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr_en", 1, 0);
        end else begin
          w = wr_q.pop_front();
          tests++;
          if (int'(bus.wr_layer) != w.l || int'(bus.wr_addr) != w.a || int'(bus.wr_data) != w.d) begin
            fails++;
            $display("FAIL write: got L%0d A%0d D%0d expected L%0d A%0d D%0d",
                     bus.wr_layer, bus.wr_addr, int'(bus.wr_data), w.l, w.a, w.d);
          end
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          r = res_q.pop_front();
          check("num_out", int'(num_out), r.num);
          check("overflow", int'(overflow), r.ovf);
          check("busy_at_done", int'(busy), 0);
          check("cycles", cyc - start_cyc, r.cycles);
        end
      end
      done_prev = done;
    end
  end

  task automatic push_writes(input int n0, input int n1);
    wr_t w;
    int  v;
    for (int i = 0; i < n0 + n1; i++) begin
      w.l = (i < n0) ? 0 : 1;
      w.a = (i < n0) ? i : i - n0;
      v   = mac_val(w.l, w.a);
      w.d = (v < 0) ? 0 : v;
      wr_q.push_back(w);
    end
  endtask

  task automatic push_result(input int num, input int ovf, input int cycles);
    res_t r;
    r.num = num; r.ovf = ovf; r.cycles = cycles;
    res_q.push_back(r);
  endtask

  task automatic start_run();
    @(negedge sysClk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge sysClk);
    start     = 1'b0;
  endtask

  task automatic pulse_start_busy();
    @(negedge sysClk);
    start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      @(negedge sysClk);
      k++;
    end
    if (!done) check("wait_done_timeout", 0, 1);
    @(negedge sysClk);
    check("wr_q_drained", wr_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_done"},       int'(done), 0);
    check({tag, "_num_out"},    int'(num_out), 0);
    check({tag, "_overflow"},   int'(overflow), 0);
    check({tag, "_mac_start"},  int'(bus.mac_start), 0);
    check({tag, "_wr_en"},      int'(bus.wr_en), 0);
    check({tag, "_wr_data"},    int'(bus.wr_data), 0);
    check({tag, "_mac_layer"},  int'(bus.mac_layer), 0);
    check({tag, "_mac_neuron"}, int'(bus.mac_neuron), 0);
  endtask

  initial begin
    int k, n_ms, n_wr, n_dn;
    iRst_n = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge sysClk);
    iRst_n = 1'b1;
    @(negedge sysClk);
    check_idle_outputs("reset");

    // Baseline: hidden = neuron index, digit 7 wins
    push_writes(64, 32);
    push_result(7, 0, 743);
    start_run();
    wait_done(2000);

    // Same run with start pulses while busy: nothing may change
    push_writes(64, 32);
    push_result(7, 0, 743);
    start_run();
    repeat (100) @(negedge sysClk);
    pulse_start_busy();
    repeat (333) @(negedge sysClk);
    pulse_start_busy();
    wait_done(2000);

    // Negative hidden results clamp to 0; all-equal final layer picks 0
    hid_neg = 1; l2_mode = 1;
    push_writes(64, 32);
    push_result(0, 0, 743);
    start_run();
    wait_done(2000);

    // Extreme final-layer values: max at neuron 9, min elsewhere
    hid_neg = 0; l2_mode = 2;
    push_writes(64, 32);
    push_result(9, 0, 743);
    start_run();
    wait_done(2000);

    // Single saturation pulse on layer 0 neuron 3
    l2_mode = 0; ovf_l = 0; ovf_n = 3;
    push_writes(64, 32);
    push_result(7, 1, 743);
    start_run();
    wait_done(2000);

    // Restart after done clears overflow and done
    ovf_l = -1; ovf_n = -1;
    push_writes(64, 32);
    push_result(7, 0, 743);
    start_run();
    check("restart_overflow", int'(overflow), 0);
    check("restart_done", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    wait_done(2000);

    // MAC hangs on layer 1 neuron 0: 64*7 + 1 + 4096 + 1 cycles
    hang_l = 1; hang_n = 0;
    push_writes(64, 0);
    push_result(15, 1, 4546);
    start_run();
    wait_done(6000);

    // Reset in WAIT of layer 1 neuron 5; the MAC's late mac_done must be ignored
    hang_l = -1; hang_n = -1;
    push_writes(64, 5);
    start_run();
    k = 0;
    while (!(bus.mac_start && bus.mac_layer == 2'd1 && bus.mac_neuron == 10'd5) && k < 2000) begin
      @(negedge sysClk);
      k++;
    end
    check("reached_l1_n5", int'(bus.mac_start), 1);
    repeat (2) @(negedge sysClk);
    iRst_n = 1'b0;
    @(negedge sysClk);
    iRst_n = 1'b1;
    check_idle_outputs("midrst");
    n_ms = 0; n_wr = 0; n_dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysClk);
      if (bus.mac_start) n_ms++;
      if (bus.wr_en) n_wr++;
      if (done || busy) n_dn++;
    end
    check("midrst_no_mac_start", n_ms, 0);
    check("midrst_no_wr_en", n_wr, 0);
    check("midrst_stays_idle", n_dn, 0);
    check("midrst_wr_q_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
